fusion_mac_ctrl: RTL and testbench
==================================

# fusion_mac_ctrl

Sequencing controller for the 8x8 bit-fusion MAC tile. It accepts a job (precision mode plus dot-product length) and streams operand pairs into the fusion unit. It drives the 20-bit shift configuration words for the selected precision and tracks the fusion unit's one-cycle registered output. It accumulates that output into a wide signed accumulator and returns one result per job over a valid/ready handshake.

## Interface
- LEN_W, 8: width of job length; max beats = 2^LEN_W-1
- ACC_W, 32: accumulator/result width (>= 20)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  job request pulse; sampled only in IDLE
- mode  in  2  00 = 2-bit, 01 = 4-bit, 10 = 8-bit, 11 = reserved
- len  in  LEN_W  number of operand beats; 0 treated as 1
- cfg_err  out  1  one-cycle pulse when start arrives with mode 11
- busy  out  1  high in any state other than IDLE
- op_valid / op_ready  in/out  1  operand handshake
- op_a, op_b  in  8  packed operand bytes
- fu_in1, fu_in2  out  8  to fusion unit in1/in2
- fu_sft0, fu_sft1  out  20  to fusion unit sft0/sft1
- fu_out  in  20  fusion unit registered output
- res_valid / res_ready  out/in  1  result handshake
- res_data  out  ACC_W  signed accumulated dot product

## Operation
- States:
  - IDLE -> RUN on start with mode != 11. Latches mode and len, clears acc and beat counter.
  - start with mode 11 pulses cfg_err and the block stays in IDLE.
- RUN:
  - op_ready = 1 while beats accepted < len.
  - Each accepted beat registers op_a/op_b into fu_in1/fu_in2.
  - Non-beat cycles drive fu_in1/fu_in2 = 0.
  - After the last beat is accepted, go to DRAIN.
- DRAIN: wait until the 2-deep valid pipeline is empty, then go to DONE.
- DONE:
  - res_valid = 1 and res_data = acc, both held stable until res_ready.
  - On the handshake, go to IDLE.
- Valid pipeline: v0 is set on the edge a beat is accepted (fu_in valid); v1 = v0 delayed one cycle (fu_out valid). When v1 = 1, acc <= acc + sign_extend(fu_out[19]).
- Accumulation wraps modulo 2^ACC_W; there is no saturation.
- Shift words are driven from the latched mode for the whole job, and are 0 in IDLE. Per-block code is {sft1[i], sft0[i]}: 00 = x1, 01 = <<2, 10 = <<4, 11 = <<8.
  - mode 00: fu_sft0 = 0x00000, fu_sft1 = 0x00000 (16 independent 2x2 products summed).
  - mode 01: fu_sft0 = 0x06666, fu_sft1 = 0x08888. Inner codes per group are 00,01,01,10 and outer codes are 00, giving four 4x4 products summed.
  - mode 10: fu_sft0 = 0x86666, fu_sft1 = 0xE8888. Inner codes as mode 01; outer codes are group0 00, group1 10, group2 10, group3 11, giving one 8x8 product.
- start outside IDLE is ignored; no queueing.
- op_valid while op_ready = 0 is ignored; the data is not consumed.
- Async reset at any time:
  - State -> IDLE; acc, counter and pipeline cleared.
  - All outputs 0: op_ready, busy, res_valid, res_data, cfg_err, fu_in1/2, fu_sft0/1.
  - Any in-flight job is discarded.

## Timing
- start sampled at edge S:
  - busy = 1 after S.
  - op_ready = 1 after S.
  - fu_sft* valid after S.
- Beat accepted at edge E: fu_in* valid after E. The fusion unit registers the product at E+1. acc updates at E+2.
- Last beat accepted at edge L: DONE entered and res_valid = 1 after L+2.
- Minimum job, len = 1 with op_valid held high: start at S, beat at S+1, res_valid after S+3.
- Full throughput: one beat per cycle when op_valid is continuous.
- res_valid to IDLE: one cycle after the res_ready handshake. A new start is accepted the following edge.
- cfg_err: high for exactly the one cycle after the offending start edge.

## Test plan
- MODE8, len 3, beats (3,5), (10,20), (127,2), op_valid continuous -> res_data = 469; res_valid rises 2 cycles after the last beat; fu_sft0/1 = 0x86666/0xE8888 throughout RUN.
- MODE4, len 2, beats (0x21,0x13) twice -> per beat 1*3 + 2*3 + 1*1 + 2*1 = 12, res_data = 24; fu_sft0/1 = 0x06666/0x08888.
- MODE2, len 4, beats (0x55,0x55) with op_valid toggling 1,0,1,0 -> op_ready stays high until 4 beats are accepted; res_data = 64; fu_in* = 0 on gap cycles.
- Result backpressure: res_ready held low for 5 cycles -> res_valid and res_data stable; a start pulse during DONE is ignored; the handshake then returns to IDLE with busy = 0.
- mode 11 start -> cfg_err high for 1 cycle; busy stays 0; op_ready stays 0.
- rst_n low mid-RUN after 2 of 4 beats -> all outputs 0 immediately; a new MODE8 job (2,2), len 1, after release gives res_data = 4 with no residue from the aborted job.

Source files
------------

// File: rtl/fusion_mac_ctrl.sv
// Sequencing controller for the 8x8 bit-fusion MAC tile: streams operand beats
// into the fusion unit, drives its shift configuration and accumulates the products.
module fusion_mac_ctrl #(
  parameter int unsigned LEN_W = 8,
  parameter int unsigned ACC_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [LEN_W-1:0]  len,
  output logic              cfg_err,
  output logic              busy,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [7:0]        op_a,
  input  logic [7:0]        op_b,
  output logic [7:0]        fu_in1,
  output logic [7:0]        fu_in2,
  output logic [19:0]       fu_sft0,
  output logic [19:0]       fu_sft1,
  input  logic [19:0]       fu_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data
);

  localparam int unsigned FU_W = 20;
  localparam int unsigned EXT_W = ACC_W - FU_W;

  localparam logic [1:0] MODE_2B  = 2'b00;
  localparam logic [1:0] MODE_4B  = 2'b01;
  localparam logic [1:0] MODE_8B  = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state_q, state_n;
  logic [1:0]        mode_q, mode_n;
  logic [LEN_W-1:0]  len_q, len_n;
  logic [LEN_W-1:0]  cnt_q, cnt_n;
  logic              acc_clr;
  logic              cfg_err_n;
  logic [FU_W-1:0]   sft0_n, sft1_n;
  logic              accept;
  logic              v0_q, v1_q;
  logic [ACC_W-1:0]  acc_q;

  assign accept   = op_ready & op_valid;
  assign res_data = acc_q;

  // Next-state and next-output decode
  always_comb begin
    state_n   = state_q;
    mode_n    = mode_q;
    len_n     = len_q;
    cnt_n     = cnt_q;
    acc_clr   = 1'b0;
    cfg_err_n = 1'b0;
    sft0_n    = '0;
    sft1_n    = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (mode == MODE_RSV) begin
            cfg_err_n = 1'b1;
          end else begin
            state_n = S_RUN;
            mode_n  = mode;
            len_n   = (len == '0) ? LEN_W'(1) : len;
            cnt_n   = '0;
            acc_clr = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (accept) begin
          cnt_n = cnt_q + LEN_W'(1);
          if (cnt_n == len_q) state_n = S_DRAIN;
        end
      end
      // Once v0 is empty the final product lands in acc on the same edge we leave
      S_DRAIN: begin
        if (!v0_q) state_n = S_DONE;
      end
      S_DONE: begin
        if (res_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    if (state_n != S_IDLE) begin
      unique case (mode_n)
        MODE_4B: begin
          sft0_n = 20'h06666;
          sft1_n = 20'h08888;
        end
        MODE_8B: begin
          sft0_n = 20'h86666;
          sft1_n = 20'hE8888;
        end
        MODE_2B, MODE_RSV: begin
          sft0_n = '0;
          sft1_n = '0;
        end
        default: begin
          sft0_n = '0;
          sft1_n = '0;
        end
      endcase
    end
  end

  // State and registered control outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mode_q    <= MODE_2B;
      len_q     <= '0;
      cnt_q     <= '0;
      busy      <= 1'b0;
      op_ready  <= 1'b0;
      res_valid <= 1'b0;
      cfg_err   <= 1'b0;
      fu_sft0   <= '0;
      fu_sft1   <= '0;
    end else begin
      state_q   <= state_n;
      mode_q    <= mode_n;
      len_q     <= len_n;
      cnt_q     <= cnt_n;
      busy      <= (state_n != S_IDLE);
      op_ready  <= (state_n == S_RUN);
      res_valid <= (state_n == S_DONE);
      cfg_err   <= cfg_err_n;
      fu_sft0   <= sft0_n;
      fu_sft1   <= sft1_n;
    end
  end

  // Operand launch and valid pipeline tracking the fusion unit latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fu_in1 <= '0;
      fu_in2 <= '0;
      v0_q   <= 1'b0;
      v1_q   <= 1'b0;
    end else begin
      fu_in1 <= accept ? op_a : 8'h00;
      fu_in2 <= accept ? op_b : 8'h00;
      v0_q   <= accept;
      v1_q   <= v0_q;
    end
  end

  // Wrapping signed accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (acc_clr) begin
      acc_q <= '0;
    end else if (v1_q) begin
      acc_q <= acc_q + {{EXT_W{fu_out[FU_W-1]}}, fu_out};
    end
  end

endmodule

// File: tb/tb_fusion_mac_ctrl.sv
// Directed self-checking bench for fusion_mac_ctrl with a behavioural fusion unit.
module tb_fusion_mac_ctrl;

  localparam int unsigned LEN_W = 8;
  localparam int unsigned ACC_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [1:0]        mode;
  logic [LEN_W-1:0]  len;
  logic              cfg_err;
  logic              busy;
  logic              op_valid;
  logic              op_ready;
  logic [7:0]        op_a, op_b;
  logic [7:0]        fu_in1, fu_in2;
  logic [19:0]       fu_sft0, fu_sft1;
  logic [19:0]       fu_out = '0;
  logic              res_valid;
  logic              res_ready;
  logic [ACC_W-1:0]  res_data;

  int errors = 0;
  int checks = 0;
  logic [1:0] tb_mode = 2'b00;

  fusion_mac_ctrl #(.LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .len(len),
    .cfg_err(cfg_err), .busy(busy), .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .fu_in1(fu_in1), .fu_in2(fu_in2),
    .fu_sft0(fu_sft0), .fu_sft1(fu_sft1), .fu_out(fu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  always #5 clk = ~clk;

  // Unsigned sum of all sub-block cross products for the chosen precision
  function automatic logic [19:0] fu_model(input logic [1:0] m, input logic [7:0] a,
                                           input logic [7:0] b);
    logic [19:0] sa, sb;
    sa = '0;
    sb = '0;
    if (m == 2'b00) begin
      for (int i = 0; i < 4; i++) begin
        sa = sa + 20'(a[2*i +: 2]);
        sb = sb + 20'(b[2*i +: 2]);
      end
    end else if (m == 2'b01) begin
      sa = 20'(a[3:0]) + 20'(a[7:4]);
      sb = 20'(b[3:0]) + 20'(b[7:4]);
    end else begin
      sa = 20'(a);
      sb = 20'(b);
    end
    return 20'(sa * sb);
  endfunction

  always @(posedge clk) fu_out <= fu_model(tb_mode, fu_in1, fu_in2);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_op_ready"}, 32'(op_ready), 32'd0);
    chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_res_data"}, res_data, 32'd0);
    chk({tag, "_cfg_err"}, 32'(cfg_err), 32'd0);
    chk({tag, "_fu_in"}, {16'd0, fu_in1, fu_in2}, 32'd0);
    chk({tag, "_fu_sft0"}, 32'(fu_sft0), 32'd0);
    chk({tag, "_fu_sft1"}, 32'(fu_sft1), 32'd0);
  endtask

  task automatic wait_res(input string tag);
    int n = 0;
    while (!res_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_res_valid_timeout"}, 32'(res_valid), 32'd1);
  endtask

  task automatic launch(input logic [1:0] m, input logic [LEN_W-1:0] l);
    tb_mode = m;
    start = 1'b1;
    mode  = m;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  task automatic handshake(input string tag);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle_res_valid"}, 32'(res_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mode = 2'b00;
    len = '0;
    op_valid = 1'b0;
    op_a = '0;
    op_b = '0;
    res_ready = 1'b0;
    #1;
    chk_all_zero("reset");
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // MODE8, len 3, continuous beats: 15 + 200 + 254 = 469
    launch(2'b10, 8'd3);
    chk("m8_busy", 32'(busy), 32'd1);
    chk("m8_op_ready", 32'(op_ready), 32'd1);
    chk("m8_sft0", 32'(fu_sft0), 32'h86666);
    chk("m8_sft1", 32'(fu_sft1), 32'hE8888);
    op_valid = 1'b1; op_a = 8'd3; op_b = 8'd5;
    tick();
    chk("m8_fu_in1_b0", 32'(fu_in1), 32'd3);
    chk("m8_fu_in2_b0", 32'(fu_in2), 32'd5);
    op_a = 8'd10; op_b = 8'd20;
    tick();
    op_a = 8'd127; op_b = 8'd2;
    tick();
    op_valid = 1'b0;
    chk("m8_op_ready_after_last", 32'(op_ready), 32'd0);
    chk("m8_fu_in1_last", 32'(fu_in1), 32'd127);
    chk("m8_res_valid_L", 32'(res_valid), 32'd0);
    tick();
    chk("m8_res_valid_L1", 32'(res_valid), 32'd0);
    chk("m8_fu_in1_gap", 32'(fu_in1), 32'd0);
    tick();
    chk("m8_res_valid_L2", 32'(res_valid), 32'd1);
    chk("m8_res_data", res_data, 32'd469);
    chk("m8_sft0_done", 32'(fu_sft0), 32'h86666);
    handshake("m8");
    chk("m8_sft0_idle", 32'(fu_sft0), 32'd0);

    // MODE4, len 2, (0x21,0x13) twice: 12 per beat
    launch(2'b01, 8'd2);
    chk("m4_sft0", 32'(fu_sft0), 32'h06666);
    chk("m4_sft1", 32'(fu_sft1), 32'h08888);
    op_valid = 1'b1; op_a = 8'h21; op_b = 8'h13;
    tick();
    tick();
    op_valid = 1'b0;
    wait_res("m4");
    chk("m4_res_data", res_data, 32'd24);
    handshake("m4");

    // MODE2, len 4, op_valid toggling: 16 per beat
    launch(2'b00, 8'd4);
    chk("m2_sft0", 32'(fu_sft0), 32'd0);
    chk("m2_sft1", 32'(fu_sft1), 32'd0);
    op_a = 8'h55; op_b = 8'h55;
    for (int i = 0; i < 7; i++) begin
      op_valid = (i % 2 == 0);
      tick();
      chk($sformatf("m2_op_ready_%0d", i), 32'(op_ready), (i < 6) ? 32'd1 : 32'd0);
      chk($sformatf("m2_fu_in1_%0d", i), 32'(fu_in1), (i % 2 == 0) ? 32'h55 : 32'd0);
    end
    op_valid = 1'b0;
    wait_res("m2");
    chk("m2_res_data", res_data, 32'd64);

    // Result backpressure with a stray start during DONE
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      mode = 2'b10;
      len = 8'd1;
      tick();
      chk($sformatf("bp_res_valid_%0d", i), 32'(res_valid), 32'd1);
      chk($sformatf("bp_res_data_%0d", i), res_data, 32'd64);
    end
    start = 1'b0;
    chk("bp_op_ready", 32'(op_ready), 32'd0);
    handshake("bp");

    // Reserved mode start
    tb_mode = 2'b11;
    start = 1'b1; mode = 2'b11; len = 8'd1;
    tick();
    start = 1'b0;
    chk("rsv_cfg_err", 32'(cfg_err), 32'd1);
    chk("rsv_busy", 32'(busy), 32'd0);
    chk("rsv_op_ready", 32'(op_ready), 32'd0);
    tick();
    chk("rsv_cfg_err_drop", 32'(cfg_err), 32'd0);
    chk("rsv_busy2", 32'(busy), 32'd0);

    // len 0 behaves as one beat: 1*1 in MODE8
    launch(2'b10, 8'd0);
    op_valid = 1'b1; op_a = 8'd1; op_b = 8'd1;
    tick();
    op_valid = 1'b0;
    chk("len0_op_ready", 32'(op_ready), 32'd0);
    wait_res("len0");
    chk("len0_res_data", res_data, 32'd1);
    handshake("len0");

    // Abort mid-RUN with async reset, then a clean MODE8 job (2,2)
    launch(2'b10, 8'd4);
    op_valid = 1'b1; op_a = 8'd9; op_b = 8'd9;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("abort");
    op_valid = 1'b0;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_all_zero("post_reset");
    launch(2'b10, 8'd1);
    op_valid = 1'b1; op_a = 8'd2; op_b = 8'd2;
    tick();
    op_valid = 1'b0;
    tick();
    chk("rst_job_res_valid_L1", 32'(res_valid), 32'd0);
    tick();
    chk("rst_job_res_valid_L2", 32'(res_valid), 32'd1);
    chk("rst_job_res_data", res_data, 32'd4);
    handshake("rst_job");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
